// File: rtl/fetch_queue_unit.sv
// Instruction fetch stage: direct-mapped I-cache, static JAL/predicted-branch redirect,
// decoupled instruction queue to decode. Optional cache via `FETCH_ICACHE_EN (absent => every fetch misses).
module fetch_queue_unit #(
    parameter int          ICACHE_LINES = 128,
    parameter int          IQ_DEPTH     = 8,
    parameter int          BP_TAG_BITS  = 8,
    parameter logic [31:0] RESET_PC     = 32'h0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    output logic                   out_mem_ce,
    output logic [31:0]            out_mem_pc,
    input  logic                   in_mem_ce,
    input  logic [31:0]            in_mem_instr,
    output logic [BP_TAG_BITS-1:0] out_bp_tag,
    input  logic                   in_bp_jump_ce,
    output logic                   out_dec_valid,
    input  logic                   in_dec_ready,
    output logic [31:0]            out_dec_instr,
    output logic [31:0]            out_dec_pc,
    output logic                   out_dec_jump_ce,
    input  logic                   in_rob_misbranch,
    input  logic [31:0]            in_rob_newpc
);

    localparam int IDX = $clog2(ICACHE_LINES);
    localparam int QW  = $clog2(IQ_DEPTH);
    localparam int CW  = QW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(IQ_DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT_MEM, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic            out_mem_ce_q, out_mem_ce_d;
    logic [31:0]     out_mem_pc_q, out_mem_pc_d;
    logic [QW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;

    logic [31:0]     iq_instr [IQ_DEPTH];
    logic [31:0]     iq_pc    [IQ_DEPTH];
    logic            iq_jump  [IQ_DEPTH];

    logic            hit;
    logic [31:0]     cache_data;
    logic [31:0]     fetch_instr;
    logic            is_jal, is_br, push_jump, push, pop;
    logic [31:0]     imm_j, imm_b, npc;
    logic [CW-1:0]   count_after_pop;

`ifdef FETCH_ICACHE_EN
    logic [ICACHE_LINES-1:0] valid_q;
    logic [29-IDX:0]         tag_mem  [ICACHE_LINES];
    logic [31:0]             data_mem [ICACHE_LINES];
    logic                    fill_en;

    // Fill always targets the requested address; pc may have been redirected during DRAIN.
    assign fill_en    = rdy && in_mem_ce && (state_q == WAIT_MEM || state_q == DRAIN);
    assign hit        = valid_q[pc_q[IDX+1:2]] && (tag_mem[pc_q[IDX+1:2]] == pc_q[31:IDX+2]);
    assign cache_data = data_mem[pc_q[IDX+1:2]];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (fill_en) begin
            valid_q[out_mem_pc_q[IDX+1:2]] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && fill_en) begin
            tag_mem[out_mem_pc_q[IDX+1:2]]  <= out_mem_pc_q[31:IDX+2];
            data_mem[out_mem_pc_q[IDX+1:2]] <= in_mem_instr;
        end
    end
`else
    assign hit        = 1'b0;
    assign cache_data = 32'h0;
`endif

    assign fetch_instr = (state_q == IDLE) ? cache_data : in_mem_instr;
    assign is_jal      = (fetch_instr[6:0] == 7'b1101111);
    assign is_br       = (fetch_instr[6:0] == 7'b1100011);
    assign push_jump   = is_br && in_bp_jump_ce;
    assign imm_j = {{11{fetch_instr[31]}}, fetch_instr[31], fetch_instr[19:12],
                    fetch_instr[20], fetch_instr[30:21], 1'b0};
    assign imm_b = {{19{fetch_instr[31]}}, fetch_instr[31], fetch_instr[7],
                    fetch_instr[30:25], fetch_instr[11:8], 1'b0};
    assign npc   = is_jal ? pc_q + imm_j : (push_jump ? pc_q + imm_b : pc_q + 32'd4);

    assign out_dec_valid   = (count_q != '0);
    assign pop             = out_dec_valid && in_dec_ready;
    assign count_after_pop = count_q - CW'(pop);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        out_mem_ce_d = 1'b0;
        out_mem_pc_d = out_mem_pc_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        push         = 1'b0;
        if (in_rob_misbranch) begin
            pc_d    = in_rob_newpc;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            case (state_q)
                WAIT_MEM: state_d = in_mem_ce ? IDLE : DRAIN;
                DRAIN:    state_d = in_mem_ce ? IDLE : DRAIN;
                default:  state_d = IDLE;
            endcase
        end else begin
            case (state_q)
                IDLE: begin
                    // A miss reserves its IQ slot here, so the response can always push.
                    if (count_after_pop < DEPTH_C) begin
                        if (hit) begin
                            push = 1'b1;
                            pc_d = npc;
                        end else begin
                            out_mem_ce_d = 1'b1;
                            out_mem_pc_d = pc_q;
                            state_d      = WAIT_MEM;
                        end
                    end
                end
                WAIT_MEM: begin
                    if (in_mem_ce) begin
                        push    = 1'b1;
                        pc_d    = npc;
                        state_d = IDLE;
                    end
                end
                DRAIN: begin
                    if (in_mem_ce) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
            head_d  = head_q + QW'(pop);
            tail_d  = tail_q + QW'(push);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            out_mem_ce_q <= 1'b0;
            out_mem_pc_q <= 32'h0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
        end else if (rdy) begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            out_mem_ce_q <= out_mem_ce_d;
            out_mem_pc_q <= out_mem_pc_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && rdy && push) begin
            iq_instr[tail_q] <= fetch_instr;
            iq_pc[tail_q]    <= pc_q;
            iq_jump[tail_q]  <= push_jump;
        end
    end

    assign out_mem_ce      = out_mem_ce_q && rdy;
    assign out_mem_pc      = out_mem_pc_q;
    assign out_bp_tag      = pc_q[BP_TAG_BITS+1:2];
    assign out_dec_instr   = iq_instr[head_q];
    assign out_dec_pc      = iq_pc[head_q];
    assign out_dec_jump_ce = iq_jump[head_q];

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit: bench-side instruction memory, pop log and
// hand-computed expectations. Expectations that depend on `FETCH_ICACHE_EN follow that macro.
module tb_fetch_queue_unit;

`ifdef FETCH_ICACHE_EN
    localparam bit HAS_CACHE = 1'b1;
`else
    localparam bit HAS_CACHE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        out_mem_ce;
    logic [31:0] out_mem_pc;
    logic        in_mem_ce = 1'b0;
    logic [31:0] in_mem_instr = 32'h0;
    logic [7:0]  out_bp_tag;
    logic        in_bp_jump_ce = 1'b0;
    logic        out_dec_valid;
    logic        in_dec_ready = 1'b0;
    logic [31:0] out_dec_instr;
    logic [31:0] out_dec_pc;
    logic        out_dec_jump_ce;
    logic        in_rob_misbranch = 1'b0;
    logic [31:0] in_rob_newpc = 32'h0;

    fetch_queue_unit dut (
        .clk              (clk),
        .rst              (rst),
        .rdy              (rdy),
        .out_mem_ce       (out_mem_ce),
        .out_mem_pc       (out_mem_pc),
        .in_mem_ce        (in_mem_ce),
        .in_mem_instr     (in_mem_instr),
        .out_bp_tag       (out_bp_tag),
        .in_bp_jump_ce    (in_bp_jump_ce),
        .out_dec_valid    (out_dec_valid),
        .in_dec_ready     (in_dec_ready),
        .out_dec_instr    (out_dec_instr),
        .out_dec_pc       (out_dec_pc),
        .out_dec_jump_ce  (out_dec_jump_ce),
        .in_rob_misbranch (in_rob_misbranch),
        .in_rob_newpc     (in_rob_newpc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [256];
    logic        mem_pend = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    int          req_cnt  = 0;
    logic [31:0] req_pc   [$];
    logic [31:0] pop_pc   [$];
    logic        pop_jump [$];
    logic [31:0] pop_instr[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // One clock: log the decode handshake before the edge, then run the memory model
    // (response arrives on the second cycle after the request becomes visible).
    task automatic tick();
        if (!rst && rdy && out_dec_valid && in_dec_ready && !in_rob_misbranch) begin
            pop_pc.push_back(out_dec_pc);
            pop_jump.push_back(out_dec_jump_ce);
            pop_instr.push_back(out_dec_instr);
        end
        @(posedge clk);
        #1;
        if (in_mem_ce) in_mem_ce = 1'b0;
        if (mem_pend) begin
            in_mem_ce    = 1'b1;
            in_mem_instr = mem[mem_addr[9:2]];
            mem_pend     = 1'b0;
        end
        if (out_mem_ce) begin
            mem_pend = 1'b1;
            mem_addr = out_mem_pc;
            req_cnt++;
            req_pc.push_back(out_mem_pc);
        end
    endtask

    task automatic flush(input logic [31:0] newpc);
        in_rob_misbranch = 1'b1;
        in_rob_newpc     = newpc;
        tick();
        in_rob_misbranch = 1'b0;
    endtask

    task automatic clear_logs();
        pop_pc.delete();
        pop_jump.delete();
        pop_instr.delete();
        req_pc.delete();
        req_cnt = 0;
    endtask

    logic [31:0] exp_loop_pc [9] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h20, 32'h1C, 32'h20, 32'h1C};
    logic        exp_loop_j  [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h00000013;
        mem[4] = 32'h0100006F;   // 0x10: JAL +16
        mem[8] = 32'hFE000EE3;   // 0x20: branch -4

        // reset
        tick();
        tick();
        check("rst_mem_ce", {31'h0, out_mem_ce}, 32'h0);
        check("rst_mem_pc", out_mem_pc, 32'h0);
        check("rst_dec_valid", {31'h0, out_dec_valid}, 32'h0);
        check("rst_bp_tag", {24'h0, out_bp_tag}, 32'h0);

        rst = 1'b0;
        tick();
        check("first_req_ce", {31'h0, out_mem_ce}, 32'h1);
        check("first_req_pc", out_mem_pc, 32'h0);
        tick();
        check("req_pulse_one_cycle", {31'h0, out_mem_ce}, 32'h0);
        tick();
        check("first_push_valid", {31'h0, out_dec_valid}, 32'h1);
        check("first_push_pc", out_dec_pc, 32'h0);
        check("first_push_instr", out_dec_instr, 32'h00000013);
        check("first_push_jump", {31'h0, out_dec_jump_ce}, 32'h0);
        tick();
        check("second_req_ce", {31'h0, out_mem_ce}, 32'h1);
        check("second_req_pc", out_mem_pc, 32'h4);

        // straight line, JAL, predicted-taken branch loop
        clear_logs();
        in_dec_ready  = 1'b1;
        in_bp_jump_ce = 1'b1;
        for (int i = 0; i < 300 && pop_pc.size() < 9; i++) tick();
        check("loop_pops_seen", {31'h0, pop_pc.size() >= 9}, 32'h1);
        if (pop_pc.size() >= 9) begin
            for (int i = 0; i < 9; i++) begin
                check($sformatf("loop_pc_%0d", i), pop_pc[i], exp_loop_pc[i]);
                check($sformatf("loop_jump_%0d", i), {31'h0, pop_jump[i]}, {31'h0, exp_loop_j[i]});
            end
            check("loop_jal_instr", pop_instr[4], 32'h0100006F);
            check("loop_br_instr", pop_instr[5], 32'hFE000EE3);
        end
        req_cnt = 0;
        for (int i = 0; i < 20; i++) tick();
        check("loop_no_refetch", {31'h0, req_cnt == 0}, {31'h0, HAS_CACHE});

        // back-pressure: IQ fills to 8 entries and pc stalls at 0xA0
        in_dec_ready = 1'b0;
        flush(32'h80);
        check("flush_empties_iq", {31'h0, out_dec_valid}, 32'h0);
        for (int i = 0; i < 60; i++) tick();
        check("full_head_pc", out_dec_pc, 32'h80);
        check("full_pc_stalled", {24'h0, out_bp_tag}, 32'h28);
        req_cnt = 0;
        for (int i = 0; i < 10; i++) tick();
        check("full_no_request", req_cnt, 0);
        check("full_pc_still", {24'h0, out_bp_tag}, 32'h28);

        // rdy low freezes everything, including the decode handshake
        rdy          = 1'b0;
        in_dec_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("rdy_low_mem_ce", {31'h0, out_mem_ce}, 32'h0);
        check("rdy_low_head", out_dec_pc, 32'h80);
        rdy = 1'b1;

        // one-cycle ready: exactly one pop and one push
        clear_logs();
        tick();
        in_dec_ready = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("one_pop_count", pop_pc.size(), 1);
        if (pop_pc.size() >= 1) check("one_pop_pc", pop_pc[0], 32'h80);
        check("one_push_pc", {24'h0, out_bp_tag}, 32'h29);
        check("one_pop_head", out_dec_pc, 32'h84);
        clear_logs();
        in_dec_ready = 1'b1;
        for (int i = 0; i < 100 && pop_pc.size() < 9; i++) tick();
        in_dec_ready = 1'b0;
        check("drain_pops_seen", {31'h0, pop_pc.size() >= 9}, 32'h1);
        if (pop_pc.size() >= 9)
            for (int i = 0; i < 9; i++)
                check($sformatf("drain_pc_%0d", i), pop_pc[i], 32'h84 + 32'(4 * i));

        // misbranch while waiting on 0x40
        flush(32'h40);
        for (int i = 0; i < 10 && !(out_mem_ce && out_mem_pc == 32'h40); i++) tick();
        check("wait40_req_seen", {31'h0, out_mem_ce && out_mem_pc == 32'h40}, 32'h1);
        clear_logs();
        flush(32'h100);
        check("wait40_flush_valid", {31'h0, out_dec_valid}, 32'h0);
        tick();
        check("wait40_resp_not_pushed", {31'h0, out_dec_valid}, 32'h0);
        for (int i = 0; i < 10 && !out_mem_ce; i++) tick();
        check("redirect_req_ce", {31'h0, out_mem_ce}, 32'h1);
        check("redirect_req_pc", out_mem_pc, 32'h100);
        for (int i = 0; i < 40; i++) tick();
        flush(32'h40);
        tick();
        check("line40_cached_ce", {31'h0, out_mem_ce}, {31'h0, !HAS_CACHE});
        check("line40_cached_push", {31'h0, out_dec_valid}, {31'h0, HAS_CACHE});

        // misbranch together with pop (and hit push when cached)
        in_dec_ready = 1'b1;
        flush(32'h1C);
        for (int i = 0; i < 12; i++) tick();
        for (int i = 0; i < 20 && !out_dec_valid; i++) tick();
        check("mb_pop_valid_before", {31'h0, out_dec_valid}, 32'h1);
        clear_logs();
        flush(32'h200);
        check("mb_pop_valid_after", {31'h0, out_dec_valid}, 32'h0);
        check("mb_pop_pc_after", {24'h0, out_bp_tag}, 32'h80);
        for (int i = 0; i < 30 && pop_pc.size() < 1; i++) tick();
        check("mb_pop_seen", {31'h0, pop_pc.size() >= 1}, 32'h1);
        if (pop_pc.size() >= 1) check("mb_no_stale_pc", pop_pc[0], 32'h200);
        if (req_pc.size() >= 1) check("mb_first_req", req_pc[0], 32'h200);
        else check("mb_first_req_seen", req_pc.size(), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
